serial_word_tx: RTL and testbench

Parallel-to-serial transmitter that feeds bit-serial datapath blocks such as the bit-serial two's complementer. Accepts WIDTH-bit words over a valid/ready handshake and emits them LSB first, one bit per clock, with start-of-word and end-of-word strobes. A strobe lets a downstream serial block clear its per-word state. A one-word holding buffer allows gapless back-to-back words.

---
 rtl/serial_pkg.sv | 16 +
 rtl/word_hold_buf.sv | 44 ++++
 rtl/serial_word_tx.sv | 96 +++++++++
 tb/tb_serial_word_tx.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the bit-serial datapath blocks.
package serial_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } tx_state_e;

  localparam int DEFAULT_WIDTH = 8;

  // Bit-counter width for a w-bit word; never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/word_hold_buf.sv
// One-entry holding buffer for the word that follows the one being shifted.
module word_hold_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             take_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] hold_o,
  output logic             pending_o,
  output logic             ready_o
);

  logic [WIDTH-1:0] hold_q, hold_d;
  logic             pend_q, pend_d;

  always_comb begin
    hold_d = hold_q;
    pend_d = pend_q;
    if (load_i) begin
      hold_d = data_i;
      pend_d = 1'b1;
    end else if (take_i) begin
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_q <= '0;
      pend_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      pend_q <= pend_d;
    end
  end

  assign hold_o    = hold_q;
  assign pending_o = pend_q;
  // Ready is held low for as long as reset is asserted, not just after the edge.
  assign ready_o   = rst & ~pend_q;

endmodule

// File: rtl/serial_word_tx.sv
// Parallel-to-serial word transmitter, LSB first, with sof/eof strobes.
module serial_word_tx
  import serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] word_in,
  input  logic             word_valid,
  output logic             word_ready,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             sof,
  output logic             eof
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  tx_state_e        state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             load_hold, take_hold, pending;
  logic [WIDTH-1:0] hold;
  logic             accept;

  assign accept = word_valid & word_ready;

  word_hold_buf #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clk      (clk),
    .rst      (rst),
    .load_i   (load_hold),
    .take_i   (take_hold),
    .data_i   (word_in),
    .hold_o   (hold),
    .pending_o(pending),
    .ready_o  (word_ready)
  );

  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    cnt_d     = cnt_q;
    load_hold = 1'b0;
    take_hold = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          sh_d    = word_in;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q != LAST) begin
          sh_d      = sh_q >> 1;
          cnt_d     = cnt_q + CW'(1);
          load_hold = accept;
        end else if (pending) begin
          sh_d      = hold;
          take_hold = 1'b1;
          cnt_d     = '0;
        end else if (accept) begin
          // Direct load keeps the stream gapless when the buffer is empty.
          sh_d  = word_in;
          cnt_d = '0;
        end else begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bit_valid = (state_q == SHIFT);
  assign bit_out   = bit_valid & sh_q[0];
  assign sof       = bit_valid & (cnt_q == '0);
  assign eof       = bit_valid & (cnt_q == LAST);

endmodule

// File: tb/tb_serial_word_tx.sv
// Randomized and directed bench for serial_word_tx against a word-schedule model.
module tb_serial_word_tx;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] word_in = '0;
  logic         word_valid = 1'b0;
  logic         word_ready, bit_out, bit_valid, sof, eof;

  always #5 clk = ~clk;

  serial_word_tx #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .word_in   (word_in),
    .word_valid(word_valid),
    .word_ready(word_ready),
    .bit_out   (bit_out),
    .bit_valid (bit_valid),
    .sof       (sof),
    .eof       (eof)
  );

  // Each accepted word is transmitted over edges [start, start+W); its start is
  // the later of its accept edge and the end of the previous word.
  typedef struct {
    logic [W-1:0] w;
    longint       acc;
    longint       start;
  } ent_t;

  ent_t         sched[$];
  longint       edge_n = 0;
  longint       last_start = -1000;
  bit           in_reset = 1'b1;
  int           vectors = 0;
  int           miscompares = 0;

  logic [W-1:0] col_word, tc_word;
  int           col_idx = 0;
  bit           seen_one = 1'b0;
  logic [W-1:0] out_words[$];
  logic [W-1:0] tc_words[$];
  longint       sof_edges[$];
  longint       eof_edges[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  function automatic bit exp_ready();
    if (in_reset) return 1'b0;
    foreach (sched[i])
      if (sched[i].acc <= edge_n && edge_n < sched[i].start) return 1'b0;
    return 1'b1;
  endfunction

  task automatic check_cycle();
    logic eb, ev, es, ee;
    eb = 0; ev = 0; es = 0; ee = 0;
    if (!in_reset)
      foreach (sched[i])
        if (edge_n >= sched[i].start && edge_n < sched[i].start + W) begin
          int p = int'(edge_n - sched[i].start);
          eb = sched[i].w[p];
          ev = 1'b1;
          es = (p == 0);
          ee = (p == W - 1);
        end
    check("bit_valid", 32'(bit_valid), 32'(ev));
    check("bit_out", 32'(bit_out), 32'(eb));
    check("sof", 32'(sof), 32'(es));
    check("eof", 32'(eof), 32'(ee));
    check("word_ready", 32'(word_ready), 32'(exp_ready()));
    // Collector plus a serial two's complementer cleared on sof.
    if (bit_valid) begin
      if (sof) begin
        col_idx = 0;
        seen_one = 1'b0;
        sof_edges.push_back(edge_n);
      end
      if (col_idx < W) begin
        col_word[col_idx] = bit_out;
        tc_word[col_idx]  = seen_one ? ~bit_out : bit_out;
      end
      seen_one = seen_one | bit_out;
      col_idx++;
      if (eof) begin
        out_words.push_back(col_word);
        tc_words.push_back(tc_word);
        eof_edges.push_back(edge_n);
      end
    end
  endtask

  task automatic step(input logic v, input logic [W-1:0] d, output bit accepted);
    bit rdy;
    ent_t e;
    word_valid = v;
    word_in    = d;
    rdy        = exp_ready();
    @(posedge clk);
    edge_n++;
    while (sched.size() > 0 && sched[0].start + W <= edge_n) void'(sched.pop_front());
    accepted = v && rdy;
    if (accepted) begin
      e.w     = d;
      e.acc   = edge_n;
      e.start = (edge_n > last_start + W) ? edge_n : last_start + W;
      last_start = e.start;
      sched.push_back(e);
    end
    #1;
    check_cycle();
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) step(1'b0, '0, a);
  endtask

  task automatic do_reset(input int hold_cycles);
    rst = 1'b0;
    in_reset = 1'b1;
    sched.delete();
    last_start = -1000;
    col_idx = W;
    #1;
    check_cycle();
    for (int i = 0; i < hold_cycles; i++) begin
      @(posedge clk);
      edge_n++;
      #1;
      check_cycle();
    end
    rst = 1'b1;
    in_reset = 1'b0;
  endtask

  task automatic clear_logs();
    out_words.delete();
    tc_words.delete();
    sof_edges.delete();
    eof_edges.delete();
  endtask

  task automatic expect_word(input string tag, input logic [W-1:0] exp);
    logic [W-1:0] got;
    got = (out_words.size() > 0) ? out_words.pop_front() : 'x;
    check(tag, 32'(got), 32'(exp));
  endtask

  initial begin
    bit a;
    logic [W-1:0] three[3];
    int idx;

    #2;
    check_cycle();
    repeat (2) begin
      @(posedge clk);
      edge_n++;
      #1;
      check_cycle();
    end
    rst = 1'b1;
    in_reset = 1'b0;

    // Single word.
    clear_logs();
    step(1'b1, 8'hB4, a);
    idle(10);
    check("b4_count", 32'(out_words.size()), 32'd1);
    expect_word("b4_word", 8'hB4);

    // Back-to-back with valid held.
    clear_logs();
    step(1'b1, 8'h01, a);
    step(1'b1, 8'hFF, a);
    idle(18);
    expect_word("b2b_w0", 8'h01);
    expect_word("b2b_w1", 8'hFF);
    check("b2b_gap", 32'(sof_edges[1] - sof_edges[0]), 32'(W));

    // Three words offered continuously.
    clear_logs();
    three = '{8'h11, 8'h22, 8'h33};
    idx = 0;
    for (int c = 0; c < 60 && idx < 3; c++) begin
      step(1'b1, three[idx], a);
      if (a) idx++;
    end
    check("three_accepted", 32'(idx), 32'd3);
    idle(30);
    expect_word("three_w0", 8'h11);
    expect_word("three_w1", 8'h22);
    expect_word("three_w2", 8'h33);

    // Reset mid-word with a pending word.
    clear_logs();
    step(1'b1, 8'hAA, a);
    step(1'b1, 8'h55, a);
    idle(2);
    do_reset(3);
    clear_logs();
    step(1'b1, 8'h0F, a);
    idle(12);
    check("rst_count", 32'(out_words.size()), 32'd1);
    expect_word("rst_word", 8'h0F);

    // Accept on the last-bit edge with an empty buffer.
    clear_logs();
    step(1'b1, 8'h80, a);
    idle(7);
    step(1'b1, 8'h01, a);
    idle(10);
    expect_word("eofload_w0", 8'h80);
    expect_word("eofload_w1", 8'h01);
    check("eofload_sof_after_eof", 32'(sof_edges[1] - eof_edges[0]), 32'd1);

    // Serial two's complement of 6.
    clear_logs();
    step(1'b1, 8'h06, a);
    idle(10);
    check("twos_comp", 32'(tc_words.size() > 0 ? tc_words[0] : 8'h00), 32'h00FA);

    // Randomized traffic with occasional mid-stream resets.
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 99) == 0) do_reset($urandom_range(1, 3));
      else step(($urandom_range(0, 2) != 0), W'($urandom), a);
    end
    idle(20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
